// File: rtl/mor1kx_branch_resolver.sv
// mor1kx_branch_resolver
//   Execute-stage resolution of conditional branches (l.bf / l.bnf).
//   A branch leaving decode is captured with its predicted direction. The
//   unit then waits for the architectural flag and compares the real outcome
//   with the prediction. A wrong prediction produces a one-cycle flush pulse
//   with the correct fetch PC. The unit also feeds the resolve-side inputs of
//   the gshare predictor and keeps saturating accuracy counters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   padv_decode_i            decode advances this cycle
//   decode_op_bf_i/bnf_i     decode holds l.bf / l.bnf (bf wins if both)
//   decode_predicted_flag_i  predicted direction (1 = taken)
//   decode_pc_i/target_i     branch PC / taken target
//   flag_i, flag_valid_i     SR[F] and its "final" qualifier
//   execute_op_bf/bnf_o      opcode held in execute
//   prev_op_brcond_o         conditional branch held in execute
//   stall_o                  execute branch still waiting for the flag
//   branch_mispredict_o      one-cycle flush pulse
//   redirect_pc_o            correct fetch PC while the pulse is high
//   branch_count_o           resolved branches (saturating)
//   mispredict_count_o       mispredicted branches (saturating)
module mor1kx_branch_resolver #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int CNT_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_decode_i,
    input  logic                            decode_op_bf_i,
    input  logic                            decode_op_bnf_i,
    input  logic                            decode_predicted_flag_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
    input  logic                            flag_i,
    input  logic                            flag_valid_i,
    output logic                            execute_op_bf_o,
    output logic                            execute_op_bnf_o,
    output logic                            prev_op_brcond_o,
    output logic                            stall_o,
    output logic                            branch_mispredict_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic [CNT_WIDTH-1:0]            branch_count_o,
    output logic [CNT_WIDTH-1:0]            mispredict_count_o
);

    localparam int W = OPTION_OPERAND_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Execute-stage copy of the branch.
    logic            r_bf;
    logic            r_bnf;
    logic            r_pred;
    logic [W-1:0]    r_pc;
    logic [W-1:0]    r_target;
    // Set once the held branch has been resolved but decode has not moved on,
    // so the same branch is neither re-counted nor stalls again.
    logic            r_resolved;
    logic [W-1:0]    r_redirect;
    logic [CNT_WIDTH-1:0] r_branch_cnt;
    logic [CNT_WIDTH-1:0] r_mispred_cnt;

    logic            w_exec;
    logic            w_stall;
    logic            w_capture;
    logic            w_resolve;
    logic            w_taken;
    logic            w_mispredict;
    logic            w_load;
    logic            w_clear;
    logic            w_set_resolved;

    assign w_exec       = (r_state == S_EXEC);
    assign w_stall      = w_exec & ~r_resolved & ~flag_valid_i;
    // A decode advance while the execute branch is stalled is not a real
    // advance, so it can neither capture nor retire anything.
    assign w_capture    = padv_decode_i & (r_state != S_FLUSH) & ~w_stall &
                          (decode_op_bf_i | decode_op_bnf_i);
    assign w_resolve    = w_exec & ~r_resolved & flag_valid_i;
    assign w_taken      = (r_bf & flag_i) | (r_bnf & ~flag_i);
    assign w_mispredict = w_resolve & (w_taken != r_pred);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath control.
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_clear        = 1'b0;
        w_set_resolved = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_EXEC;
                    w_load      = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_mispredict) begin
                    // Anything arriving from decode now is wrong-path.
                    w_state_nxt = S_FLUSH;
                    w_clear     = 1'b1;
                end else if (w_capture) begin
                    w_load = 1'b1;
                end else if (padv_decode_i & ~w_stall) begin
                    w_state_nxt = S_IDLE;
                    w_clear     = 1'b1;
                end else if (w_resolve) begin
                    w_set_resolved = 1'b1;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_clear     = 1'b1;
            end
        endcase
    end

    // Execute-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bf       <= 1'b0;
            r_bnf      <= 1'b0;
            r_pred     <= 1'b0;
            r_pc       <= '0;
            r_target   <= '0;
            r_resolved <= 1'b0;
        end else if (w_load) begin
            r_bf       <= decode_op_bf_i;
            r_bnf      <= decode_op_bnf_i & ~decode_op_bf_i;
            r_pred     <= decode_predicted_flag_i;
            r_pc       <= decode_pc_i;
            r_target   <= decode_target_i;
            r_resolved <= 1'b0;
        end else if (w_clear) begin
            r_bf       <= 1'b0;
            r_bnf      <= 1'b0;
            r_pred     <= 1'b0;
            r_pc       <= '0;
            r_target   <= '0;
            r_resolved <= 1'b0;
        end else if (w_set_resolved) begin
            r_resolved <= 1'b1;
        end
    end

    // Redirect PC: not-taken resumes after the delay slot (PC + 8, wraps).
    always_ff @(posedge clk) begin
        if (rst)               r_redirect <= '0;
        else if (w_mispredict) r_redirect <= w_taken ? r_target : r_pc + W'(8);
    end

    // Saturating statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispredict && r_mispred_cnt != '1)
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign execute_op_bf_o     = w_exec & r_bf;
    assign execute_op_bnf_o    = w_exec & r_bnf;
    assign prev_op_brcond_o    = w_exec;
    assign stall_o             = w_stall;
    assign branch_mispredict_o = (r_state == S_FLUSH);
    // Only meaningful alongside the flush pulse; zero otherwise.
    assign redirect_pc_o       = (r_state == S_FLUSH) ? r_redirect : '0;
    assign branch_count_o      = r_branch_cnt;
    assign mispredict_count_o  = r_mispred_cnt;

endmodule

// File: doc/mor1kx_branch_resolver.md
# mor1kx_branch_resolver

Execute-stage branch resolution unit for conditional branches (l.bf / l.bnf). It captures the decode-stage prediction when a branch leaves decode, waits for the architectural flag, and compares the actual outcome against the prediction. On a mismatch it issues a one-cycle mispredict/flush pulse with the correct redirect PC. It also drives the resolve-side signals consumed by the gshare predictor (`execute_op_bf_o`, `execute_op_bnf_o`, `prev_op_brcond_o`, `branch_mispredict_o`) and keeps saturating accuracy counters.

## Interface
- `OPTION_OPERAND_WIDTH`, 32, PC/target width.
- `CNT_WIDTH`, 16, width of the statistics counters.

- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `padv_decode_i`  in  1  decode stage advances this cycle.
- `decode_op_bf_i`  in  1  decode instruction is l.bf.
- `decode_op_bnf_i`  in  1  decode instruction is l.bnf.
- `decode_predicted_flag_i`  in  1  predictor output for the decode branch (1 = predicted taken).
- `decode_pc_i`  in  W  PC of the decode branch.
- `decode_target_i`  in  W  taken target of the decode branch.
- `flag_i`  in  1  architectural SR[F].
- `flag_valid_i`  in  1  `flag_i` is final for the branch in execute.
- `execute_op_bf_o`  out  1  l.bf held in execute.
- `execute_op_bnf_o`  out  1  l.bnf held in execute.
- `prev_op_brcond_o`  out  1  conditional branch held in execute.
- `stall_o`  out  1  branch in execute is waiting for the flag; upstream must hold.
- `branch_mispredict_o`  out  1  one-cycle flush pulse.
- `redirect_pc_o`  out  W  correct fetch PC; valid while `branch_mispredict_o` is high.
- `branch_count_o`  out  CNT_WIDTH  resolved branches, saturating.
- `mispredict_count_o`  out  CNT_WIDTH  mispredicted branches, saturating.

## Operation
- Three states: IDLE, EXEC, FLUSH. Execute-stage registers hold bf, bnf, predicted flag, PC and target.
- **Capture.** When `padv_decode_i` is high, state is not FLUSH, and (`decode_op_bf_i` or `decode_op_bnf_i`) is set, load the registers and enter EXEC.
  - If both bf and bnf are asserted, bf wins.
  - `padv_decode_i` while `stall_o` is high is ignored.
- **EXEC.**
  - `execute_op_*_o` reflect the held opcode.
  - `prev_op_brcond_o` = 1.
  - `stall_o` = !`flag_valid_i`.
- **Resolve.** Occurs in EXEC when `flag_valid_i` = 1:
  - taken = (bf & `flag_i`) | (bnf & !`flag_i`).
  - mispredict = taken != held predicted flag.
  - Increment `branch_count_o`; if mispredict, also increment `mispredict_count_o`. Both saturate at all-ones.
- **Next state after resolve.**
  - Mispredict: go to FLUSH. Register `redirect_pc_o` = taken ? target : PC + 8 (past the delay slot; addition modulo 2^W, wraps). Clear the execute registers. Any branch being captured from decode in the same cycle is wrong-path and is discarded.
  - Correct prediction, new branch captured the same cycle: stay in EXEC with the new branch.
  - Correct prediction, otherwise: if `padv_decode_i`, go to IDLE and clear the execute registers. If `padv_decode_i` is low, hold in EXEC with flag resolved; do not re-count until the next capture.
- **FLUSH.** `branch_mispredict_o` = 1 for exactly this cycle. Decode captures are blocked. Next state is IDLE.
- **IDLE.** All branch outputs are 0 except the counters.
- **Reset values.** State IDLE; all outputs 0, including `redirect_pc_o` and both counters. Reset wins over every other event, including in FLUSH, where it aborts the pulse.

## Timing
- Capture at cycle t → EXEC outputs valid at t+1.
- If `flag_valid_i` is high at t+1 and the branch mispredicts, `branch_mispredict_o` and `redirect_pc_o` are asserted at t+2, and state returns to IDLE at t+3.
- Resolve latency = 1 + (cycles with `flag_valid_i` low). `stall_o` is combinational from the state and `flag_valid_i`.
- Back-to-back correctly predicted branches sustain one branch per cycle.
- After a mispredict, the minimum gap before the next capture is 1 cycle (the FLUSH cycle).
- The execute outputs are stable for the whole EXEC residency. The predictor updates on `prev_op_brcond_o` & `padv_decode_i` using `flag_i`.

## Test plan
- **Correct taken prediction.** bf, predicted 1, PC 0x100, target 0x200, `flag_i` = 1 with `flag_valid_i` at t+1 → no mispredict, `branch_count_o` = 1, `mispredict_count_o` = 0.
- **Wrong not-taken prediction.** bnf, predicted 1, PC 0x100, `flag_i` = 1 → `branch_mispredict_o` high for 1 cycle at t+2, `redirect_pc_o` = 0x108, `mispredict_count_o` = 1.
- **Flag wait.** `flag_valid_i` low for 3 cycles → `stall_o` high for exactly 3 cycles; resolution happens on the 4th; counters increment once.
- **Mispredict with simultaneous decode branch.** Mispredict resolves while a new bf is captured in the same cycle → new branch discarded, IDLE after FLUSH, `branch_count_o` increments only once.
- **Saturation and wrap.** Preload via 2^CNT_WIDTH+2 branches with CNT_WIDTH=4 → counters hold 0xF. Mispredict not-taken with PC 0xFFFFFFFC → `redirect_pc_o` = 0x00000004.
- **Reset during FLUSH.** Assert `rst` in the FLUSH cycle → next cycle all outputs 0 and state IDLE.
